// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// cpu_mem_responder - unified RAM, LED register and switch port for the CPU bus
// Revision: 1.0
// ============================================================================
module cpu_mem_responder #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 9,
  parameter int                RAM_DEPTH      = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR       = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR        = 9'h140,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ready,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              bus_err
);

  localparam int                PTR_W    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RAM_END  = ADDR_W'(RAM_DEPTH);
  localparam logic [PTR_W-1:0]  CLR_LAST = PTR_W'(RAM_DEPTH - 1);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_clr_ptr;
  logic [7:0]        r_sw_meta;
  logic [7:0]        r_sw_sync;
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic              w_in_ram;
  logic              w_is_led;
  logic              w_is_sw;
  logic              w_ram_we;
  logic [PTR_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0] w_ram_din;
  logic [PTR_W-1:0]  w_rd_idx;

  assign w_in_ram = (mem_addr < RAM_END);
  assign w_is_led = (mem_addr == LED_ADDR);
  assign w_is_sw  = (mem_addr == SW_ADDR);
  assign w_rd_idx = mem_addr[PTR_W-1:0];

  // The clear engine and CPU writes share the single RAM write port.
  assign w_ram_we  = !reset && ((r_state == ST_CLEAR) ||
                                (mem_cmd == CMD_WRITE && w_in_ram));
  assign w_ram_idx = (r_state == ST_CLEAR) ? r_clr_ptr : w_rd_idx;
  assign w_ram_din = (r_state == ST_CLEAR) ? '0 : mem_wdata;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      ram[w_ram_idx] <= w_ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      r_clr_ptr <= '0;
      mem_rdata <= '0;
      ready     <= 1'b0;
      led       <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == CLR_LAST) begin
            r_state <= ST_SERVE;
            ready   <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          case (mem_cmd)
            CMD_READ: begin
              if (w_in_ram) begin
                mem_rdata <= ram[w_rd_idx];
              end else if (w_is_led) begin
                mem_rdata <= DATA_W'(led);
              end else if (w_is_sw) begin
                mem_rdata <= DATA_W'(r_sw_sync);
              end else begin
                mem_rdata <= '0;
                bus_err   <= 1'b1;
              end
            end
            CMD_WRITE: begin
              // RAM writes land through the shared write port above.
              if (w_is_led) begin
                led <= mem_wdata[7:0];
              end else if (!w_in_ram) begin
                bus_err <= 1'b1;
              end
            end
            CMD_ILL:  bus_err <= 1'b1;
            CMD_NONE: ;
            default:  ;
          endcase
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cpu_mem_responder - vector table, corner sequences and randomized model check
// Revision: 1.0
// ============================================================================
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset, reset0;
  logic [1:0]  mem_cmd, mem_cmd0;
  logic [8:0]  mem_addr, mem_addr0;
  logic [15:0] mem_wdata, mem_wdata0;
  logic [15:0] mem_rdata, mem_rdata0;
  logic        ready, ready0;
  logic [7:0]  sw, sw0;
  logic [7:0]  led, led0;
  logic        bus_err, bus_err0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ready(ready),
    .sw(sw), .led(led), .bus_err(bus_err)
  );

  cpu_mem_responder #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .mem_cmd(mem_cmd0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .ready(ready0),
    .sw(sw0), .led(led0), .bus_err(bus_err0)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  swv;
    logic [15:0] rdata;
    logic [7:0]  ledv;
    logic        err;
  } vec_t;

  vec_t tbl[14];

  // Reference state for the randomized phase
  logic [15:0] m_ram [256];
  logic [15:0] m_rd;
  logic [7:0]  m_led;
  logic        m_err;
  logic [7:0]  m_sw_d1, m_sw_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd = c; mem_addr = a; mem_wdata = d;
  endtask

  task automatic wait_ready(output int edges, output bit rd_nonzero);
    edges = -1;
    rd_nonzero = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (mem_rdata != 16'h0) rd_nonzero = 1'b1;
      if (ready) begin
        edges = i;
        break;
      end
    end
  endtask

  // One serving edge of the reference: read data comes from the switch
  // value sampled two edges earlier.
  task automatic model_edge(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    int ai;
    ai = int'(a);
    if (c == 2'b01) begin
      if (ai < 256)         m_rd = m_ram[ai];
      else if (ai == 'h100) m_rd = {8'h00, m_led};
      else if (ai == 'h140) m_rd = {8'h00, m_sw_d2};
      else begin m_rd = 16'h0; m_err = 1'b1; end
    end else if (c == 2'b10) begin
      if (ai < 256)         m_ram[ai] = d;
      else if (ai == 'h100) m_led = d[7:0];
      else                  m_err = 1'b1;
    end else if (c == 2'b11) begin
      m_err = 1'b1;
    end
    m_sw_d2 = m_sw_d1;
    m_sw_d1 = sw;
  endtask

  function automatic logic [8:0] pick_addr(input bit legal_read, input bit legal_write);
    logic [8:0] a;
    case ($urandom_range(0, 5))
      0: a = 9'($urandom_range(0, 15));
      1: a = 9'($urandom_range(9'h0F8, 9'h107));
      2: a = 9'h100;
      3: a = 9'h140;
      4: a = 9'($urandom_range(0, 255));
      default: a = 9'($urandom);
    endcase
    if (legal_write && a >= 9'h100) a = (a[0]) ? 9'h100 : 9'($urandom_range(0, 255));
    if (legal_read && a >= 9'h100 && a != 9'h100 && a != 9'h140) a = 9'h140;
    return a;
  endfunction

  initial begin
    int  edges;
    bit  nz;
    logic [1:0] c;
    logic [8:0] a;
    logic [15:0] d;

    tbl[0]  = '{2'b10, 9'h012, 16'hA5C3, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[1]  = '{2'b01, 9'h012, 16'h0000, 8'h00, 16'hA5C3, 8'h00, 1'b0};
    tbl[2]  = '{2'b10, 9'h0FF, 16'h0001, 8'h00, 16'hA5C3, 8'h00, 1'b0};
    tbl[3]  = '{2'b01, 9'h0FF, 16'h0000, 8'h00, 16'h0001, 8'h00, 1'b0};
    tbl[4]  = '{2'b10, 9'h100, 16'h12F0, 8'h3C, 16'h0001, 8'hF0, 1'b0};
    tbl[5]  = '{2'b01, 9'h100, 16'h0000, 8'h3C, 16'h00F0, 8'hF0, 1'b0};
    tbl[6]  = '{2'b01, 9'h000, 16'h0000, 8'h3C, 16'h0000, 8'hF0, 1'b0};
    tbl[7]  = '{2'b01, 9'h140, 16'h0000, 8'h3C, 16'h003C, 8'hF0, 1'b0};
    tbl[8]  = '{2'b00, 9'h012, 16'hFFFF, 8'h3C, 16'h003C, 8'hF0, 1'b0};
    tbl[9]  = '{2'b01, 9'h180, 16'h0000, 8'h3C, 16'h0000, 8'hF0, 1'b1};
    tbl[10] = '{2'b10, 9'h140, 16'h5555, 8'h3C, 16'h0000, 8'hF0, 1'b1};
    tbl[11] = '{2'b01, 9'h012, 16'h0000, 8'h3C, 16'hA5C3, 8'hF0, 1'b1};
    tbl[12] = '{2'b11, 9'h0FF, 16'h9999, 8'h3C, 16'hA5C3, 8'hF0, 1'b1};
    tbl[13] = '{2'b01, 9'h101, 16'h0000, 8'h3C, 16'h0000, 8'hF0, 1'b1};

    reset = 1'b1; reset0 = 1'b1;
    drive(2'b00, 9'h0, 16'h0);
    mem_cmd0 = 2'b00; mem_addr0 = 9'h0; mem_wdata0 = 16'h0;
    sw = 8'h00; sw0 = 8'h00;
    step(); step();
    chk("reset_ready",  32'(ready),     32'(0));
    chk("reset_rdata",  32'(mem_rdata), 32'(0));
    chk("reset_led",    32'(led),       32'(0));
    chk("reset_err",    32'(bus_err),   32'(0));
    chk("reset0_ready", 32'(ready0),    32'(0));

    // First clear, then plant a value that the next clear must erase
    reset = 1'b0;
    drive(2'b01, 9'h005, 16'h0);
    wait_ready(edges, nz);
    chk("clear1_edges",   32'(edges), 32'(256));
    chk("clear1_rdata0",  32'(nz),    32'(0));
    drive(2'b10, 9'h005, 16'hBEEF); step();
    drive(2'b01, 9'h005, 16'h0);    step();
    chk("preload_beef", 32'(mem_rdata), 32'(16'hBEEF));

    reset = 1'b1; step();
    reset = 1'b0;
    wait_ready(edges, nz);
    chk("clear2_edges",  32'(edges), 32'(256));
    chk("clear2_rdata0", 32'(nz),    32'(0));
    step();
    chk("cleared_ram5", 32'(mem_rdata), 32'(0));
    chk("clear2_err",   32'(bus_err),   32'(0));

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
      sw = tbl[i].swv;
      step();
      chk($sformatf("vec%0d_rdata", i), 32'(mem_rdata), 32'(tbl[i].rdata));
      chk($sformatf("vec%0d_led", i),   32'(led),       32'(tbl[i].ledv));
      chk($sformatf("vec%0d_err", i),   32'(bus_err),   32'(tbl[i].err));
    end

    drive(2'b00, 9'h0, 16'h0);
    repeat (10) step();
    chk("err_sticky", 32'(bus_err), 32'(1));

    // Reset in the middle of a clear restarts it from the beginning
    reset = 1'b1; step();
    chk("rst_err_clr", 32'(bus_err), 32'(0));
    chk("rst_led_clr", 32'(led),     32'(0));
    reset = 1'b0;
    repeat (100) step();
    chk("midclear_ready", 32'(ready), 32'(0));
    reset = 1'b1; step();
    chk("midclear_rst_ready", 32'(ready), 32'(0));
    reset = 1'b0;
    wait_ready(edges, nz);
    chk("restart_edges", 32'(edges), 32'(256));

    // Illegal command on its own raises the error and holds read data
    drive(2'b01, 9'h012, 16'h0);    step();
    chk("recleared_012", 32'(mem_rdata), 32'(0));
    drive(2'b10, 9'h033, 16'h1234); step();
    drive(2'b01, 9'h033, 16'h0);    step();
    chk("raw_033", 32'(mem_rdata), 32'(16'h1234));
    drive(2'b11, 9'h033, 16'h0);    step();
    chk("ill_hold", 32'(mem_rdata), 32'(16'h1234));
    chk("ill_err",  32'(bus_err),   32'(1));

    // Randomized phase against the reference model
    drive(2'b00, 9'h0, 16'h0);
    reset = 1'b1; step();
    reset = 1'b0;
    wait_ready(edges, nz);
    chk("rand_clear_edges", 32'(edges), 32'(256));
    for (int i = 0; i < 256; i++) m_ram[i] = 16'h0;
    m_rd = 16'h0; m_led = 8'h0; m_err = 1'b0;
    m_sw_d1 = sw; m_sw_d2 = sw;
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        c = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        a = pick_addr(c == 2'b01, c == 2'b10);
      end else begin
        c = 2'($urandom);
        a = pick_addr(1'b0, 1'b0);
      end
      d = 16'($urandom);
      drive(c, a, d);
      model_edge(c, a, d);
      step();
      sw = 8'($urandom);
      chk("rand_rdata", 32'(mem_rdata), 32'(m_rd));
      chk("rand_led",   32'(led),       32'(m_led));
      chk("rand_err",   32'(bus_err),   32'(m_err));
    end
    drive(2'b00, 9'h0, 16'h0);

    // Access on the reset edge must be discarded (no-clear variant)
    reset0 = 1'b0; step();
    chk("noclr_ready", 32'(ready0), 32'(1));
    mem_cmd0 = 2'b10; mem_addr0 = 9'h020; mem_wdata0 = 16'h1111; step();
    mem_wdata0 = 16'h7777; reset0 = 1'b1; step();
    chk("coll_ready", 32'(ready0), 32'(0));
    chk("coll_rdata", 32'(mem_rdata0), 32'(0));
    reset0 = 1'b0;
    mem_cmd0 = 2'b01; mem_wdata0 = 16'h0; step();
    chk("coll_read", 32'(mem_rdata0), 32'(16'h1111));
    chk("coll_ready_up", 32'(ready0), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
